// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/response channel plus the decode handoff,
// bundled for the fetch sequencer. The master side is the sequencer; the
// slave side is the memory and decode logic around it.
interface fetch_sequencer_if #(
    parameter int XLEN = 32
) ();

    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_ready;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;
    logic            misaligned_fault;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        output instr_pc,
        output misaligned_fault
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        input  instr_pc,
        input  misaligned_fault
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: takes the current PC, issues one memory
// request per PC value, hands the fetched word to decode and pulses pc_en
// once decode accepts it, keeping PC and fetch in lockstep with a single
// fetch outstanding.
//
// Optional build macro FETCH_PERF_COUNTERS_EN enables the fetch_count and
// wait_cycles performance counters; without it both ports read 0.
module fetch_sequencer #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc_in,
    output logic             pc_en,
    input  logic             flush,
    fetch_sequencer_if.master bus,
    output logic [31:0]      fetch_count,
    output logic [31:0]      wait_cycles
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t          state_r;
    logic            pc_en_r;
    logic            req_valid_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic            instr_valid_r;
    logic [XLEN-1:0] instr_out_r;
    logic            fault_r;

    // Request address is always word aligned; a misaligned PC never reaches
    // the memory because IDLE diverts it straight to HOLD.
    assign bus.mem_req_valid    = req_valid_r;
    assign bus.mem_req_addr     = {fetch_pc_r[XLEN-1:2], 2'b00};
    assign bus.instr_valid      = instr_valid_r;
    assign bus.instr_out        = instr_out_r;
    assign bus.instr_pc         = fetch_pc_r;
    assign bus.misaligned_fault = fault_r;
    assign pc_en                = pc_en_r;

    // Fetch FSM with registered handshake outputs; flush beats every other
    // event, and IDLE waits out the pc_en cycle so it samples the updated PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            pc_en_r       <= 1'b0;
            req_valid_r   <= 1'b0;
            fetch_pc_r    <= {XLEN{1'b0}};
            instr_valid_r <= 1'b0;
            instr_out_r   <= RESET_INSTR;
            fault_r       <= 1'b0;
        end else begin
            pc_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (flush || pc_en_r) begin
                        state_r <= IDLE;
                    end else begin
                        fetch_pc_r <= pc_in;
                        if (pc_in[1:0] != 2'b00) begin
                            state_r       <= HOLD;
                            fault_r       <= 1'b1;
                            instr_valid_r <= 1'b1;
                            instr_out_r   <= RESET_INSTR;
                        end else begin
                            state_r     <= REQ;
                            req_valid_r <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (flush) begin
                        // A coincident ready means memory owns the request,
                        // so its response still has to be drained.
                        req_valid_r <= 1'b0;
                        state_r     <= bus.mem_req_ready ? DRAIN : IDLE;
                    end else if (bus.mem_req_ready) begin
                        req_valid_r <= 1'b0;
                        state_r     <= WAIT;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_r <= bus.mem_resp_valid ? IDLE : DRAIN;
                    end else if (bus.mem_resp_valid) begin
                        instr_out_r   <= bus.mem_resp_data;
                        instr_valid_r <= 1'b1;
                        state_r       <= HOLD;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        instr_valid_r <= 1'b0;
                        fault_r       <= 1'b0;
                        state_r       <= IDLE;
                    end else if (bus.instr_ready) begin
                        instr_valid_r <= 1'b0;
                        fault_r       <= 1'b0;
                        pc_en_r       <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                DRAIN: begin
                    if (bus.mem_resp_valid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    req_valid_r   <= 1'b0;
                    instr_valid_r <= 1'b0;
                    fault_r       <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_count_r;
    logic [31:0] wait_cycles_r;

    // Performance counters: accepted instructions and cycles spent on memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_r <= 32'd0;
            wait_cycles_r <= 32'd0;
        end else begin
            if (pc_en_r) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end else begin
                fetch_count_r <= fetch_count_r;
            end
            if ((state_r == REQ) || (state_r == WAIT)) begin
                wait_cycles_r <= wait_cycles_r + 32'd1;
            end else begin
                wait_cycles_r <= wait_cycles_r;
            end
        end
    end

    assign fetch_count = fetch_count_r;
    assign wait_cycles = wait_cycles_r;
`else
    assign fetch_count = 32'd0;
    assign wait_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. Inputs change just after the
// falling edge; outputs are inspected at the falling edge, half a cycle
// after the rising edge that produced them.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] pc_in;
    logic        pc_en;
    logic [31:0] fetch_count;
    logic [31:0] wait_cycles;
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch_sequencer_if #(.XLEN(32)) bus ();

    fetch_sequencer #(.XLEN(32), .RESET_INSTR(32'h0000_0013)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_en       (pc_en),
        .flush       (flush),
        .bus         (bus),
        .fetch_count (fetch_count),
        .wait_cycles (wait_cycles)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic do_reset(input logic [31:0] pc);
        reset = 1'b1; flush = 1'b0; pc_in = pc;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = 32'd0; bus.instr_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; pc_in = 32'h0000_0100;
        bus.mem_req_ready = 1'b0; bus.instr_ready = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hFFFF_FFFF;
        tick();
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got=%0b exp=0", bus.instr_valid); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%0b exp=0", bus.mem_req_valid); end
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en got=%0b exp=0", pc_en); end
        n_checks++; if (bus.misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%0b exp=0", bus.misaligned_fault); end
        n_checks++; if (bus.instr_out !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr_out got=%h exp=00000013", bus.instr_out); end
        n_checks++; if (bus.instr_pc !== 32'd0) begin n_fail++; $display("FAIL reset_instr_pc got=%h exp=0", bus.instr_pc); end
        n_checks++; if (bus.mem_req_addr !== 32'd0) begin n_fail++; $display("FAIL reset_req_addr got=%h exp=0", bus.mem_req_addr); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_fetch_count got=%0d exp=0", fetch_count); end
        n_checks++; if (wait_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_wait_cycles got=%0d exp=0", wait_cycles); end
        reset = 1'b0; bus.mem_resp_valid = 1'b0;
        tick();
        // IDLE after reset fetches from pc_in right away.
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_first_req got=%0b/%h exp=1/00000100", bus.mem_req_valid, bus.mem_req_addr); end
    endtask

    task automatic test_aligned_fetch;
        do_reset(32'h0000_0100);
        tick();  // REQ
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL aligned_req_valid got=%0b exp=1", bus.mem_req_valid); end
        n_checks++; if (bus.mem_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL aligned_req_addr got=%h exp=00000100", bus.mem_req_addr); end
        bus.mem_req_ready = 1'b1;
        tick();  // WAIT
        n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL aligned_wait got=%0b/%0b exp=0/0", bus.mem_req_valid, bus.instr_valid); end
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h00A0_0093;
        tick();  // HOLD: third cycle after IDLE
        n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL aligned_instr_valid got=%0b exp=1", bus.instr_valid); end
        n_checks++; if (bus.instr_out !== 32'h00A0_0093) begin n_fail++; $display("FAIL aligned_instr_out got=%h exp=00a00093", bus.instr_out); end
        n_checks++; if (bus.instr_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL aligned_instr_pc got=%h exp=00000100", bus.instr_pc); end
        n_checks++; if (pc_en !== 1'b0 || bus.misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL aligned_hold_flags got=%0b/%0b exp=0/0", pc_en, bus.misaligned_fault); end
        bus.mem_resp_valid = 1'b0; bus.instr_ready = 1'b1;
        tick();
        n_checks++; if (pc_en !== 1'b1 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL aligned_pc_en got=%0b/%0b exp=1/0", pc_en, bus.instr_valid); end
        bus.instr_ready = 1'b0;
        tick();
        n_checks++; if (pc_en !== 1'b0 || bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL aligned_pc_en_pulse got=%0b/%0b exp=0/0", pc_en, bus.mem_req_valid); end
        pc_in = 32'h0000_0104;  // PC register updated on the pc_en edge
        tick();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL aligned_next_req got=%0b/%h exp=1/00000104", bus.mem_req_valid, bus.mem_req_addr); end
    endtask

    task automatic test_backpressure;
        do_reset(32'h0000_0200);
        tick(); bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h00B0_0113;
        tick(); bus.mem_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 32'h00B0_0113 || pc_en !== 1'b0) begin n_fail++; $display("FAIL backpressure_hold[%0d] got=%0b/%h/%0b exp=1/00b00113/0", i, bus.instr_valid, bus.instr_out, pc_en); end
            // A stray response while holding must not disturb instr_out.
            bus.mem_resp_valid = (i == 1); bus.mem_resp_data = 32'hBAD0_BAD0;
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 32'h00B0_0113) begin n_fail++; $display("FAIL backpressure_before_accept got=%0b/%h exp=1/00b00113", bus.instr_valid, bus.instr_out); end
        bus.instr_ready = 1'b1;
        tick();
        n_checks++; if (pc_en !== 1'b1 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_accept got=%0b/%0b exp=1/0", pc_en, bus.instr_valid); end
        bus.instr_ready = 1'b0;
        tick();
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL backpressure_single_pulse got=%0b exp=0", pc_en); end
    endtask

    task automatic test_misaligned;
        do_reset(32'h0000_0300);
        tick(); bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h1234_5678;
        tick(); bus.mem_resp_valid = 1'b0; bus.instr_ready = 1'b1;
        tick(); bus.instr_ready = 1'b0;
        tick(); pc_in = 32'h0000_0302;
        tick();
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL misaligned_no_req got=%0b exp=0", bus.mem_req_valid); end
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.misaligned_fault !== 1'b1) begin n_fail++; $display("FAIL misaligned_flags got=%0b/%0b exp=1/1", bus.instr_valid, bus.misaligned_fault); end
        n_checks++; if (bus.instr_out !== 32'h0000_0013 || bus.instr_pc !== 32'h0000_0302) begin n_fail++; $display("FAIL misaligned_data got=%h/%h exp=00000013/00000302", bus.instr_out, bus.instr_pc); end
        bus.instr_ready = 1'b1;
        tick();
        n_checks++; if (pc_en !== 1'b1 || bus.instr_valid !== 1'b0 || bus.misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL misaligned_accept got=%0b/%0b/%0b exp=1/0/0", pc_en, bus.instr_valid, bus.misaligned_fault); end
        bus.instr_ready = 1'b0;
        tick();
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL misaligned_single_pulse got=%0b exp=0", pc_en); end
    endtask

    task automatic test_flush_wait;
        do_reset(32'h0000_0400);
        tick(); bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0; flush = 1'b1;  // WAIT
        tick(); flush = 1'b0; pc_in = 32'h0000_0500;     // DRAIN
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.instr_valid !== 1'b0 || pc_en !== 1'b0 || bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_drain[%0d] got=%0b/%0b/%0b exp=0/0/0", i, bus.instr_valid, pc_en, bus.mem_req_valid); end
            bus.mem_resp_valid = (i == 1); bus.mem_resp_data = 32'hDEAD_BEEF;
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_0500 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_refetch got=%0b/%h/%0b exp=1/00000500/0", bus.mem_req_valid, bus.mem_req_addr, bus.instr_valid); end
        bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_0011;
        tick(); bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 32'h0000_0011) begin n_fail++; $display("FAIL flush_wait_new_data got=%0b/%h exp=1/00000011", bus.instr_valid, bus.instr_out); end
    endtask

    task automatic test_flush_req_hold;
        do_reset(32'h0000_0700);
        tick(); flush = 1'b1; bus.mem_req_ready = 1'b1;  // accepted and flushed together
        tick(); flush = 1'b0; bus.mem_req_ready = 1'b0;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_withdraw got=%0b exp=0", bus.mem_req_valid); end
        tick();
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_drain got=%0b exp=0", bus.mem_req_valid); end
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h5555_5555;
        tick(); bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_discard got=%0b exp=0", bus.instr_valid); end
        tick();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_0700) begin n_fail++; $display("FAIL flush_req_refetch got=%0b/%h exp=1/00000700", bus.mem_req_valid, bus.mem_req_addr); end
        bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_0077;
        tick(); bus.mem_resp_valid = 1'b0; flush = 1'b1; bus.instr_ready = 1'b1;  // HOLD
        tick(); flush = 1'b0; bus.instr_ready = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL flush_hold got=%0b/%0b exp=0/0", bus.instr_valid, pc_en); end
        tick();
        n_checks++; if (pc_en !== 1'b0 || bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL flush_hold_refetch got=%0b/%0b exp=0/1", pc_en, bus.mem_req_valid); end
    endtask

    task automatic test_reset_hold;
        do_reset(32'h0000_0600);
        tick(); bus.mem_req_ready = 1'b1;
        tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hCAFE_0001;
        tick(); bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL reset_hold_pre got=%0b exp=1", bus.instr_valid); end
        reset = 1'b1; bus.instr_ready = 1'b1;
        tick(); reset = 1'b0; bus.instr_ready = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0 || pc_en !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL reset_hold_flags got=%0b/%0b/%0b/%0b exp=0/0/0/0", bus.instr_valid, pc_en, bus.mem_req_valid, bus.misaligned_fault); end
        n_checks++; if (bus.instr_out !== 32'h0000_0013 || bus.instr_pc !== 32'd0 || bus.mem_req_addr !== 32'd0) begin n_fail++; $display("FAIL reset_hold_data got=%h/%h/%h exp=00000013/0/0", bus.instr_out, bus.instr_pc, bus.mem_req_addr); end
        tick();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_0600) begin n_fail++; $display("FAIL reset_hold_idle got=%0b/%h exp=1/00000600", bus.mem_req_valid, bus.mem_req_addr); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc;
        logic [31:0] exp_fc;
        logic [31:0] exp_wc;
        pc = 32'h0000_0800;
        do_reset(pc);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== pc) begin n_fail++; $display("FAIL b2b_req[%0d] got=%0b/%h exp=1/%h", k, bus.mem_req_valid, bus.mem_req_addr, pc); end
            tick();
            n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== pc) begin n_fail++; $display("FAIL b2b_req_stable[%0d] got=%0b/%h exp=1/%h", k, bus.mem_req_valid, bus.mem_req_addr, pc); end
            tick(); bus.mem_req_ready = 1'b1;
            tick(); bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_1000 + k;
            tick(); bus.mem_resp_valid = 1'b0; bus.instr_ready = 1'b1;
            n_checks++; if (bus.instr_out !== (32'h0000_1000 + k) || bus.instr_pc !== pc) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h/%h exp=%h/%h", k, bus.instr_out, bus.instr_pc, 32'h0000_1000 + k, pc); end
            tick(); bus.instr_ready = 1'b0;
            tick();
            pc = pc + 32'd4; pc_in = pc;
        end
`ifdef FETCH_PERF_COUNTERS_EN
        exp_fc = 32'd5; exp_wc = 32'd20;
`else
        exp_fc = 32'd0; exp_wc = 32'd0;
`endif
        n_checks++; if (fetch_count !== exp_fc) begin n_fail++; $display("FAIL perf_fetch_count got=%0d exp=%0d", fetch_count, exp_fc); end
        n_checks++; if (wait_cycles !== exp_wc) begin n_fail++; $display("FAIL perf_wait_cycles got=%0d exp=%0d", wait_cycles, exp_wc); end
    endtask

    initial begin
        test_reset();
        test_aligned_fetch();
        test_backpressure();
        test_misaligned();
        test_flush_wait();
        test_flush_req_hold();
        test_reset_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch sequencer that consumes the program counter's current address and drives its update enable.
- Issues one request per PC value to instruction memory over a valid/ready request channel, then waits for the response.
- Presents the fetched word to decode with a valid/ready handshake.
- Pulses the PC enable only when decode accepts an instruction, so PC and fetch stay in lockstep. One fetch outstanding at a time.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_INSTR, 32'h0000_0013, value driven on instr_out after reset and on a misaligned fault (NOP).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  XLEN  current PC value from the program counter.
- pc_en  output  1  update enable to the program counter; one-cycle pulse.
- flush  input  1  pipeline redirect; discard any in-flight fetch.
- mem_req_valid  output  1  instruction memory request valid.
- mem_req_addr  output  XLEN  request address, word aligned.
- mem_req_ready  input  1  memory accepts the request.
- mem_resp_valid  input  1  response data valid; one-cycle pulse, no backpressure.
- mem_resp_data  input  XLEN  fetched instruction word.
- instr_valid  output  1  fetched instruction available to decode.
- instr_ready  input  1  decode accepts the instruction.
- instr_out  output  XLEN  instruction word.
- instr_pc  output  XLEN  address the instruction was fetched from.
- misaligned_fault  output  1  qualifies instr_valid; pc_in[1:0] was nonzero.
- fetch_count  output  32  performance counter (see Optional Feature).
- wait_cycles  output  32  performance counter (see Optional Feature).

Behaviour:
- Reset values (synchronous, one clock with reset high):
  - state = IDLE.
  - pc_en, mem_req_valid, instr_valid, misaligned_fault = 0.
  - mem_req_addr, instr_pc = 0.
  - instr_out = RESET_INSTR.
  - Counters = 0.
  - Reset overrides every state, including mid-request; a response arriving in the reset cycle is dropped.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE:
  - Latch pc_in into mem_req_addr and instr_pc.
  - If pc_in[1:0] != 0: go HOLD with misaligned_fault = 1 and instr_out = RESET_INSTR; no memory request is issued.
  - Otherwise go REQ.
- REQ:
  - mem_req_valid = 1; addr stable while valid.
  - On mem_req_ready: go WAIT. The request is accepted on the same-cycle valid && ready.
  - mem_req_valid must not drop before acceptance unless flush.
- WAIT:
  - On mem_resp_valid: register mem_resp_data into instr_out and go HOLD.
  - instr_valid rises the next cycle.
  - Minimum IDLE-to-instr_valid latency is 3 cycles with ready and response each returned in 1 cycle.
- HOLD:
  - instr_valid = 1; instr_out, instr_pc and misaligned_fault are held stable.
  - On instr_valid && instr_ready:
    - next cycle pc_en = 1 for exactly one cycle;
    - instr_valid = 0, misaligned_fault = 0;
    - go IDLE.
  - IDLE samples pc_in one cycle after pc_en, i.e. after the PC has updated.
- flush (priority over every other event in the same cycle; no pc_en pulse):
  - IDLE or REQ: go IDLE; the request is withdrawn. If mem_req_ready coincides with flush in REQ, the request counts as accepted: go DRAIN.
  - WAIT: go DRAIN, or IDLE if mem_resp_valid is in the same cycle (response dropped).
  - HOLD: instr_valid = 0, go IDLE; a simultaneous instr_ready is ignored.
  - DRAIN: further flushes are ignored.
- DRAIN: on mem_resp_valid, discard the data and go IDLE. Outputs stay invalid.
- mem_resp_valid outside WAIT/DRAIN is ignored.
- Exactly one pc_en pulse per accepted instruction; never two in consecutive cycles.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- With the macro defined:
  - fetch_count increments by 1 on each pc_en pulse.
  - wait_cycles increments by 1 each cycle in REQ or WAIT.
  - Both are 32-bit, wrap from 0xFFFF_FFFF to 0, and are cleared by reset.
- Without the macro: both ports are tied to constant 0 and no counter flops exist.

Test Plan:
- Aligned fetch, zero wait: reset, pc_in=0x0000_0100, ready and resp_data=0x00A0_0093 each returned 1 cycle after request, instr_ready=1 -> mem_req_addr=0x100, instr_valid on cycle 3, instr_out=0x00A0_0093, instr_pc=0x100, single pc_en pulse.
- Decode backpressure: instr_ready low 4 cycles -> instr_valid and instr_out held stable 4 cycles, no pc_en until the accept cycle +1.
- Misaligned: pc_in=0x0000_0102 -> no mem_req_valid, instr_valid=1 with misaligned_fault=1 and instr_out=0x0000_0013; pc_en pulses after accept.
- Flush in WAIT: flush one cycle after request acceptance, response arrives 3 cycles later -> response discarded, instr_valid never asserted, no pc_en, new request issued from the current pc_in.
- Reset mid-HOLD: assert reset while instr_valid=1 -> next cycle all outputs at reset values, state IDLE.
- With FETCH_PERF_COUNTERS_EN: 5 back-to-back fetches with 2-cycle memory ready delay -> fetch_count=5, wait_cycles=20. Without the macro, both read 0.
